// File: rtl/count_sweep_pkg.sv
// Shared types, default sizes and helpers for the counter sweep sequencer.
// No logic state lives here.
package count_sweep_pkg;

    localparam int WIDTH_DEF  = 4;
    localparam int REPS_W_DEF = 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RUN_FWD = 3'd2,
        S_RUN_BWD = 3'd3,
        S_DONE    = 3'd4
    } sweep_state_t;

    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/count_new.sv
// Loadable up/down counter; load has priority over count, result visible one cycle later.
// No flow control: en gates every step.
module count_new #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] cin,
    output logic [WIDTH-1:0] cout
);

    always_ff @(posedge clk) begin
        if (reset) begin
            cout <= '0;
        end else if (load) begin
            cout <= cin;
        end else if (en) begin
            cout <= up_down ? cout + 1'b1 : cout - 1'b1;
        end
    end

endmodule

// File: rtl/count_sweep_ctrl.sv
// Drives count_new through one-way or bounce sweeps, repeated per pass; outputs are Moore.
// Start accepted only in IDLE; leg endpoints checked one cycle after each leg, err is sticky.
module count_sweep_ctrl
    import count_sweep_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int REPS_W = REPS_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  start_val,
    input  logic [WIDTH-1:0]  end_val,
    input  logic              bounce,
    input  logic [REPS_W-1:0] reps,
    input  logic [WIDTH-1:0]  cout,
    output logic              en,
    output logic              up_down,
    output logic              load,
    output logic [WIDTH-1:0]  cin,
    output logic              busy,
    output logic              done,
    output logic              err
);

    sweep_state_t      state_q, state_d;
    logic [WIDTH-1:0]  start_q, end_q, len_q;
    logic              bounce_q, fwd_up_q;
    logic [WIDTH-1:0]  step_q, step_d;
    logic [REPS_W-1:0] pass_q, pass_d;
    logic              chk_pend_q, chk_set;
    logic [WIDTH-1:0]  chk_val_q, chk_val_d;
    logic              err_q;
    logic              accept;

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        pass_d    = pass_q;
        chk_set   = 1'b0;
        chk_val_d = chk_val_q;
        accept    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (len_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN_FWD;
                    step_d  = len_q;
                end
            end
            S_RUN_FWD: begin
                step_d = step_q - 1'b1;
                if (step_q == WIDTH'(1)) begin
                    chk_set   = 1'b1;
                    chk_val_d = end_q;
                    if (bounce_q) begin
                        state_d = S_RUN_BWD;
                        step_d  = len_q;
                    end else begin
                        pass_d  = pass_q - 1'b1;
                        state_d = (pass_q > REPS_W'(1)) ? S_LOAD : S_DONE;
                    end
                end
            end
            S_RUN_BWD: begin
                step_d = step_q - 1'b1;
                if (step_q == WIDTH'(1)) begin
                    chk_set   = 1'b1;
                    chk_val_d = start_q;
                    pass_d    = pass_q - 1'b1;
                    state_d   = (pass_q > REPS_W'(1)) ? S_LOAD : S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            start_q    <= '0;
            end_q      <= '0;
            len_q      <= '0;
            bounce_q   <= 1'b0;
            fwd_up_q   <= 1'b0;
            step_q     <= '0;
            pass_q     <= '0;
            chk_pend_q <= 1'b0;
            chk_val_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            chk_pend_q <= chk_set;
            chk_val_q  <= chk_val_d;
            if (accept) begin
                start_q  <= start_val;
                end_q    <= end_val;
                len_q    <= WIDTH'(abs_diff(32'(end_val), 32'(start_val)));
                bounce_q <= bounce;
                fwd_up_q <= (end_val >= start_val);
                pass_q   <= (reps == '0) ? REPS_W'(1) : reps;
                err_q    <= 1'b0;
            end else begin
                pass_q <= pass_d;
                // The counter has settled one cycle after the leg's last enable.
                if (chk_pend_q && (cout != chk_val_q)) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign en      = (state_q == S_LOAD) || (state_q == S_RUN_FWD) || (state_q == S_RUN_BWD);
    assign busy    = en;
    assign load    = (state_q == S_LOAD);
    assign done    = (state_q == S_DONE);
    assign up_down = (state_q == S_RUN_BWD) ? ~fwd_up_q : (en & fwd_up_q);
    assign cin     = start_q;
    assign err     = err_q;

endmodule

// File: tb/tb_count_sweep_ctrl.sv
// Directed bench for count_sweep_ctrl closed around a count_new counter.
module tb_count_sweep_ctrl;
    import count_sweep_pkg::*;

    localparam int W  = 4;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst, start, bounce, sup;
    logic [W-1:0]  start_val, end_val, cout, cin;
    logic [RW-1:0] reps;
    logic          en, up_down, load, busy, done, err;
    logic          cnt_en;

    always #5 clk = ~clk;

    assign cnt_en = en & ~sup;

    count_sweep_ctrl #(.WIDTH(W), .REPS_W(RW)) dut (
        .clk(clk), .rst(rst), .start(start), .start_val(start_val), .end_val(end_val),
        .bounce(bounce), .reps(reps), .cout(cout), .en(en), .up_down(up_down),
        .load(load), .cin(cin), .busy(busy), .done(done), .err(err)
    );

    count_new #(.WIDTH(W)) u_cnt (
        .clk(clk), .reset(~rst), .en(cnt_en), .up_down(up_down),
        .load(load), .cin(cin), .cout(cout)
    );

    typedef struct packed {
        logic         en;
        logic         up_down;
        logic         load;
        logic         busy;
        logic         done;
        logic         err;
        logic [W-1:0] cin;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic obs_t observe();
        obs_t o;
        o.en = en; o.up_down = up_down; o.load = load;
        o.busy = busy; o.done = done; o.err = err; o.cin = cin;
        return o;
    endfunction

    function automatic obs_t mk(input logic e, input logic ud, input logic ld, input logic bz,
                                input logic dn, input logic er, input logic [W-1:0] c);
        obs_t o;
        o.en = e; o.up_down = ud; o.load = ld; o.busy = bz; o.done = dn; o.err = er; o.cin = c;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_obs(input string tag, input obs_t exp);
        obs_t got;
        got = observe();
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pushes the expected per-cycle trace, fires start, then pops one entry per cycle.
    task automatic run_sweep(input logic [W-1:0] sv, input logic [W-1:0] ev, input logic b,
                             input logic [RW-1:0] r, input int exp_done, input string tag);
        int   len, passes, n, done_at;
        logic fu;
        obs_t v;
        fu     = (ev >= sv);
        len    = fu ? int'(ev) - int'(sv) : int'(sv) - int'(ev);
        passes = (r == 0) ? 1 : int'(r);
        for (int p = 0; p < passes; p++) begin
            exp_q.push_back(mk(1'b1, fu, 1'b1, 1'b1, 1'b0, 1'b0, sv));
            if (len == 0) break;
            for (int i = 0; i < len; i++) exp_q.push_back(mk(1'b1, fu, 1'b0, 1'b1, 1'b0, 1'b0, sv));
            if (b) for (int i = 0; i < len; i++) exp_q.push_back(mk(1'b1, ~fu, 1'b0, 1'b1, 1'b0, 1'b0, sv));
        end
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, sv));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, sv));

        start_val = sv; end_val = ev; bounce = b; reps = r; start = 1'b1;
        tick();
        start   = 1'b0;
        n       = 0;
        done_at = -1;
        while (exp_q.size() > 0) begin
            v = exp_q.pop_front();
            n++;
            check_obs($sformatf("%s cyc%0d", tag, n), v);
            if (done && done_at < 0) begin
                done_at = n;
                check_int({tag, " final cout"}, int'(cout), b ? int'(sv) : int'(ev));
            end
            if (exp_q.size() > 0) tick();
        end
        check_int({tag, " done cycle"}, done_at, exp_done);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        rst = 1'b0; start = 1'b0; bounce = 1'b0; sup = 1'b0;
        start_val = 4'd5; end_val = 4'd10; reps = 3'd2;

        for (int i = 0; i < 3; i++) begin
            start = ~start;
            tick();
            check_obs($sformatf("reset cyc%0d", i), '0);
            check_int($sformatf("reset cout %0d", i), int'(cout), 0);
        end
        start = 1'b0;
        rst   = 1'b1;
        tick();
        check_obs("idle after reset", '0);

        run_sweep(4'd3,  4'd9,  1'b0, 3'd1, 8,  "up");
        run_sweep(4'd11, 4'd4,  1'b0, 3'd1, 9,  "down");
        run_sweep(4'd2,  4'd5,  1'b1, 3'd2, 15, "bounce");
        run_sweep(4'd7,  4'd7,  1'b0, 3'd0, 2,  "zero");

        // start held through DONE is ignored there, then taken in the first IDLE cycle.
        start_val = 4'd1; end_val = 4'd2; bounce = 1'b0; reps = 3'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_obs("short done", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1));
        start_val = 4'd6; end_val = 4'd8; start = 1'b1;
        tick();
        check_obs("start ignored in done", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1));
        tick();
        start = 1'b0;
        check_obs("start taken in idle", mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd6));
        waited = 0;
        while (!done && waited < 20) begin
            tick();
            waited++;
        end
        check_int("retrigger done wait", waited, 3);
        check_int("retrigger cout", int'(cout), 8);
        tick();

        // Drop one increment in the forward leg of 0->5 bounce; leg check lands in cycle 7.
        start_val = 4'd0; end_val = 4'd5; bounce = 1'b1; reps = 3'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        sup = 1'b1;
        tick();
        sup = 1'b0;
        tick();
        tick();
        tick();
        check_obs("err leg end", mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0));
        check_int("err short cout", int'(cout), 4);
        tick();
        check_obs("err set", mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0));
        tick();
        check_obs("err sticky", mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0));
        rst = 1'b0;
        tick();
        check_obs("abort reset", '0);
        check_int("abort cout", int'(cout), 0);
        rst = 1'b1;
        tick();
        check_obs("idle after abort", '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
